// File: rtl/acc_ram_sched.sv
// acc_ram_sched: job sequencer for the matrix accelerator and
// arbiter sharing the single data-RAM port with the core.
module acc_ram_sched #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STALL  = 4
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [ADDR_WIDTH-1:0] cfg_src_a_i,
  input  logic [ADDR_WIDTH-1:0] cfg_src_b_i,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_i,
  input  logic [8:0]            cfg_len_i,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  core_req_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic                  core_we_i,
  input  logic [3:0]            core_be_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  acc_wr_o,
  output logic                  acc_sel_o,
  output logic [7:0]            acc_idx_o,
  output logic [DATA_WIDTH-1:0] acc_wdata_o,
  input  logic [DATA_WIDTH-1:0] acc_rdata_i,
  output logic                  acc_start_o,
  input  logic                  acc_done_i
);

  localparam int SW = $clog2(MAX_STALL + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT, STORE, DONE
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] src_a, src_b, dst;
  logic [ADDR_WIDTH-1:0] base, eaddr;
  logic [8:0]            len, idx, idx_n;
  logic [SW-1:0]         stall_cnt, stall_n;
  logic                  err_q, rv_q, wb_q, wb_sel;
  logic [7:0]            wb_idx;
  logic                  want, slot, loading, last, len_ok, accept;

  assign len_ok  = (cfg_len_i != 9'd0) && (cfg_len_i <= 9'd256);
  assign accept  = (state == IDLE) && cfg_valid_i;
  assign loading = (state == LOAD_A) || (state == LOAD_B);
  assign want    = loading || (state == STORE);
  assign slot    = want && (!core_req_i || stall_cnt == SW'(MAX_STALL));
  assign last    = (idx == len - 9'd1);

  assign core_gnt_o  = core_req_i && !slot;
  assign cfg_ready_o = (state == IDLE);
  assign err_o       = err_q;

  always_comb begin
    base = dst;
    if (state == LOAD_A) base = src_a;
    else if (state == LOAD_B) base = src_b;
  end

  // wraps modulo the RAM size by truncation
  assign eaddr = base + ADDR_WIDTH'({idx, 2'b00});

  always_comb begin
    stall_n = stall_cnt;
    if (!want || slot) stall_n = '0;
    else if (core_req_i) stall_n = stall_cnt + SW'(1);
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    done_o      = 1'b0;
    acc_start_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && len_ok) begin
          state_n = LOAD_A;
          idx_n   = '0;
        end
      end
      LOAD_A, LOAD_B, STORE: begin
        if (slot) begin
          idx_n = idx + 9'd1;
          if (last) begin
            idx_n = '0;
            if (state == LOAD_A) state_n = LOAD_B;
            else if (state == LOAD_B) state_n = START;
            else state_n = DONE;
          end
        end
      end
      START: begin
        // hold off until the last B operand has landed
        if (!wb_q) begin
          acc_start_o = 1'b1;
          state_n     = WAIT;
        end
      end
      WAIT: begin
        if (acc_done_i) begin
          state_n = STORE;
          idx_n   = '0;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_en_o    = core_req_i;
    ram_addr_o  = core_addr_i;
    ram_we_o    = core_we_i;
    ram_be_o    = core_be_i;
    ram_wdata_o = core_wdata_i;
    if (slot) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = eaddr;
      ram_we_o    = (state == STORE);
      ram_be_o    = 4'hF;
      ram_wdata_o = (state == STORE) ? acc_rdata_i : '0;
    end
  end

  assign core_rvalid_o = rv_q;
  assign core_rdata_o  = rv_q ? ram_rdata_i : '0;
  assign acc_wr_o      = wb_q;
  assign acc_sel_o     = wb_q && wb_sel;
  assign acc_wdata_o   = wb_q ? ram_rdata_i : '0;

  always_comb begin
    acc_idx_o = '0;
    if (wb_q) acc_idx_o = wb_idx;
    else if (state == STORE) acc_idx_o = idx[7:0];
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      idx       <= '0;
      stall_cnt <= '0;
      src_a     <= '0;
      src_b     <= '0;
      dst       <= '0;
      len       <= '0;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
      wb_q      <= 1'b0;
      wb_sel    <= 1'b0;
      wb_idx    <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      stall_cnt <= stall_n;
      err_q     <= accept && !len_ok;
      rv_q      <= core_gnt_o && !core_we_i;
      wb_q      <= slot && loading;
      wb_sel    <= (state == LOAD_B);
      wb_idx    <= idx[7:0];
      if (accept && len_ok) begin
        src_a <= cfg_src_a_i;
        src_b <= cfg_src_b_i;
        dst   <= cfg_dst_i;
        len   <= cfg_len_i;
      end
    end
  end

endmodule

// File: tb/tb_acc_ram_sched.sv
// tb_acc_ram_sched: directed jobs against a RAM and accelerator model,
// checking operand order, start timing, results, arbitration and reset.
module tb_acc_ram_sched;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [14:0] cfg_src_a_i = '0, cfg_src_b_i = '0, cfg_dst_i = '0;
  logic [8:0]  cfg_len_i = '0;
  logic        done_o, err_o;
  logic        core_req_i = 1'b0;
  logic [14:0] core_addr_i = '0;
  logic        core_we_i = 1'b0;
  logic [3:0]  core_be_i = '0;
  logic [31:0] core_wdata_i = '0;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        ram_en_o, ram_we_o;
  logic [14:0] ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;
  logic        acc_wr_o, acc_sel_o, acc_start_o, acc_done_i;
  logic [7:0]  acc_idx_o;
  logic [31:0] acc_wdata_o, acc_rdata_i;

  always #5 clk = ~clk;

  acc_ram_sched dut (
    .clk(clk), .rstn_i(rstn_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_src_a_i(cfg_src_a_i), .cfg_src_b_i(cfg_src_b_i),
    .cfg_dst_i(cfg_dst_i), .cfg_len_i(cfg_len_i),
    .done_o(done_o), .err_o(err_o),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i),
    .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .acc_wr_o(acc_wr_o), .acc_sel_o(acc_sel_o),
    .acc_idx_o(acc_idx_o), .acc_wdata_o(acc_wdata_o),
    .acc_rdata_i(acc_rdata_i), .acc_start_o(acc_start_o),
    .acc_done_i(acc_done_i)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] acc_fn(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input int k);
    return a + (b ^ 32'(k));
  endfunction

  function automatic int wrd(input logic [14:0] base, input int k);
    return ((int'(base) >> 2) + k) % 8192;
  endfunction

  logic [31:0] mem [0:8191];
  logic [31:0] op_a [0:255];
  logic [31:0] op_b [0:255];
  logic [31:0] acc_out [0:255];
  logic [3:0]  done_cd = '0;
  logic        done_force = 1'b0;

  assign acc_done_i  = (done_cd == 4'd1) || done_force;
  assign acc_rdata_i = acc_out[acc_idx_o];

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[14:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[14:2]];
      end
    end
    if (acc_wr_o) begin
      if (acc_sel_o) op_b[acc_idx_o] <= acc_wdata_o;
      else op_a[acc_idx_o] <= acc_wdata_o;
    end
    if (acc_start_o) begin
      for (int k = 0; k < 256; k++) acc_out[k] <= acc_fn(op_a[k], op_b[k], k);
      done_cd <= 4'd6;
    end else if (done_cd != 4'd0) begin
      done_cd <= done_cd - 4'd1;
    end
  end

  int          cyc = 0;
  logic [8:0]  wr_log [$];
  logic [31:0] wd_log [$];
  logic [14:0] eng_addr [$];
  int          slot_cyc [$];
  int          n_start, n_done, n_err, n_ram, n_eng_we;
  int          start_cyc, last_wr_cyc;
  logic        rv_pend = 1'b0;
  int          rv_w;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rstn_i) begin
      rv_pend = 1'b0;
    end else begin
      if (acc_wr_o) begin
        wr_log.push_back({acc_sel_o, acc_idx_o});
        wd_log.push_back(acc_wdata_o);
        last_wr_cyc = cyc;
      end
      if (acc_start_o) begin
        n_start++;
        start_cyc = cyc;
      end
      if (done_o) n_done++;
      if (err_o) n_err++;
      if (ram_en_o) n_ram++;
      if (ram_en_o && !core_gnt_o) begin
        eng_addr.push_back(ram_addr_o);
        slot_cyc.push_back(cyc);
        if (ram_we_o) n_eng_we++;
      end
      if (rv_pend) begin
        chk("core_rvalid", core_rvalid_o, 1);
        chk("core_rdata", core_rdata_o, init_val(rv_w));
      end
      rv_pend = core_gnt_o && !core_we_i;
      rv_w = int'(core_addr_i[14:2]);
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    wd_log.delete();
    eng_addr.delete();
    slot_cyc.delete();
    n_start = 0; n_done = 0; n_err = 0; n_ram = 0; n_eng_we = 0;
    start_cyc = 0; last_wr_cyc = 0;
  endtask

  task automatic issue(input logic [14:0] a, input logic [14:0] b,
                       input logic [14:0] d, input logic [8:0] n);
    @(posedge clk); #1;
    cfg_valid_i = 1'b1;
    cfg_src_a_i = a; cfg_src_b_i = b; cfg_dst_i = d; cfg_len_i = n;
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [14:0] a,
                         input logic [14:0] b, input logic [14:0] d,
                         input int n);
    int t, e_seq, e_res;
    logic [8:0] ev;
    clear_logs();
    issue(a, b, d, 9'(n));
    t = 0;
    while (n_done == 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_nwr"}, wr_log.size(), 2 * n);
    chk({tag, "_nstart"}, n_start, 1);
    chk({tag, "_start_gap"}, start_cyc - last_wr_cyc, 1);
    chk({tag, "_eng_acc"}, eng_addr.size(), 3 * n);
    e_seq = 0;
    for (int k = 0; k < wr_log.size() && k < 2 * n; k++) begin
      ev = (k < n) ? {1'b0, 8'(k)} : {1'b1, 8'(k - n)};
      if (wr_log[k] !== ev) e_seq++;
      if (wd_log[k] !== init_val(k < n ? wrd(a, k) : wrd(b, k - n))) e_seq++;
    end
    chk({tag, "_seq"}, e_seq, 0);
    e_res = 0;
    for (int k = 0; k < n; k++)
      if (mem[wrd(d, k)] !== acc_fn(init_val(wrd(a, k)), init_val(wrd(b, k)), k))
        e_res++;
    chk({tag, "_result"}, e_res, 0);
  endtask

  logic core_on = 1'b0;

  initial begin
    int t, gbad, wr0;
    for (int w = 0; w < 8192; w++) mem[w] = init_val(w);
    for (int k = 0; k < 256; k++) acc_out[k] = '0;
    clear_logs();

    #3;
    chk("rst_ready", cfg_ready_o, 1);
    chk("rst_outs", {done_o, err_o, core_gnt_o, core_rvalid_o, ram_en_o,
                     ram_we_o, acc_wr_o, acc_sel_o, acc_start_o}, 0);
    chk("rst_idx", acc_idx_o, 0);
    @(negedge clk);
    rstn_i = 1'b1;

    run_job("basic", 15'h0000, 15'h0400, 15'h0800, 4);
    chk("basic_dst0", eng_addr[8], 15'h0800);
    chk("basic_dst3", eng_addr[11], 15'h080C);

    fork
      run_job("contend", 15'h0000, 15'h0400, 15'h0800, 4);
      begin
        core_on = 1'b1;
        t = 0;
        while (core_on) begin
          @(posedge clk); #1;
          core_req_i = 1'b1;
          core_addr_i = 15'h1000 + 15'(4 * (t % 8));
          t++;
          if (n_done != 0) core_on = 1'b0;
        end
        core_req_i = 1'b0;
      end
    join
    gbad = 0;
    for (int k = 1; k < slot_cyc.size(); k++)
      if (k != 8 && slot_cyc[k] - slot_cyc[k-1] != 5) gbad++;
    chk("contend_gaps", gbad, 0);
    @(negedge clk);

    run_job("wrap", 15'h7FF0, 15'h2000, 15'h4000, 256);
    chk("wrap_a3", eng_addr[3], 15'h7FFC);
    chk("wrap_a4", eng_addr[4], 15'h0000);
    chk("wrap_last", wr_log[wr_log.size()-1], {1'b1, 8'd255});

    for (int v = 0; v < 2; v++) begin
      clear_logs();
      issue(15'h0000, 15'h0400, 15'h0800, (v == 0) ? 9'd0 : 9'd300);
      @(negedge clk);
      chk("err_pulse", err_o, 1);
      @(negedge clk);
      chk("err_clear", err_o, 0);
      repeat (4) @(negedge clk);
      chk("err_cnt", n_err, 1);
      chk("err_ram", n_ram, 0);
      chk("err_acc", wr_log.size(), 0);
      chk("err_ready", cfg_ready_o, 1);
    end

    fork
      run_job("ignore", 15'h0100, 15'h0500, 15'h0C00, 6);
      begin
        t = 0;
        while (wr_log.size() < 1 && t < 100) begin @(posedge clk); t++; end
        #1 done_force = 1'b1;
        @(posedge clk); #1 done_force = 1'b0;
        t = 0;
        while (n_start == 0 && t < 200) begin @(posedge clk); t++; end
        #1;
        cfg_valid_i = 1'b1;
        cfg_src_a_i = 15'h3000; cfg_len_i = 9'd3;
        repeat (2) @(posedge clk);
        #1 cfg_valid_i = 1'b0;
      end
    join
    wr0 = wr_log.size();
    repeat (10) @(negedge clk);
    chk("ignore_nojob", wr_log.size(), wr0);

    clear_logs();
    issue(15'h1400, 15'h1800, 15'h4800, 9'd8);
    t = 0;
    while (n_eng_we < 2 && t < 500) begin @(posedge clk); t++; end
    chk("abort_reached", n_eng_we >= 2, 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("abort_ready", cfg_ready_o, 1);
    chk("abort_outs", {done_o, err_o, core_gnt_o, core_rvalid_o, ram_en_o,
                       ram_we_o, acc_wr_o, acc_start_o}, 0);
    chk("abort_idx", acc_idx_o, 0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;

    run_job("after_rst", 15'h1400, 15'h1800, 15'h5000, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
